alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  N each  requester 0 operands.
REQ-007 req0_sel  input  4  requester 0 ALU opcode.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as REQ-004..REQ-007, for requester 1.
REQ-009 alu_a, alu_b  output  N each  operands to shared ALU.
REQ-010 alu_sel  output  4  opcode to shared ALU.
REQ-011 alu_out  input  N  ALU result.
REQ-012 alu_z, alu_v, alu_s, alu_c  input  1 each  ALU zero/overflow/sign/carry flags.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumer accepts.
REQ-015 rsp_id  output  1  requester owning the response.
REQ-016 rsp_data  output  N  captured result.
REQ-017 rsp_flags  output  4  captured {Z,V,S,C}.
REQ-018 rsp_err  output  1  unsupported opcode.

Function
REQ-019 FSM states IDLE, EXEC, RESP; one operation in flight at most.
REQ-020 IDLE: if any reqN_valid, grant exactly one; assert its reqN_ready combinationally that cycle; latch a, b, sel, id into operand registers.
REQ-021 reqN_ready SHALL be 0 outside IDLE and 0 for the non-granted requester.
REQ-022 Supported opcodes: 0000,0001,0011,0100,0101,0111,1000,1001,1010,1101,1111.
REQ-023 IDLE grant with supported opcode -> EXEC; unsupported -> RESP directly with rsp_err=1, rsp_data=0, rsp_flags=0.
REQ-024 alu_a/alu_b/alu_sel driven from operand registers at all times.
REQ-025 EXEC lasts exactly one cycle; at its end capture alu_out into rsp_data, flags into rsp_flags, rsp_err=0; -> RESP.
REQ-026 Latency: accept at cycle T -> rsp_valid high at T+2 (supported) or T+1 (unsupported).
REQ-027 RESP: rsp_valid=1; rsp_id/data/flags/err stable until rsp_valid&&rsp_ready; then -> IDLE, rsp_valid=0 next cycle.
REQ-028 No new acceptance in the cycle the response is consumed; earliest next accept is the following IDLE cycle.
REQ-029 Round-robin: both valid -> grant the requester not granted most recently; single valid -> grant it; last-grant pointer updates only on acceptance.
REQ-030 Requests dropped (valid deasserted) before acceptance leave no state effect.

Reset
REQ-031 rst high at a clock edge: state IDLE, operand registers 0, rsp_data 0, rsp_flags 0, rsp_err 0, rsp_id 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-032 rst in EXEC or RESP aborts the operation; the response is discarded and never presented.
REQ-033 While rst is high, req0_ready, req1_ready, rsp_valid SHALL be 0.

Configuration
REQ-034 Macro ALU_ARB_FIXED_PRI_EN defined: fixed priority, requester 0 always wins ties; last-grant pointer absent.
REQ-035 Macro undefined: round-robin per REQ-029.

Verification
REQ-036 After reset, req0 ADD (sel 0000) a=5 b=7, rsp_ready=1 -> rsp_valid at T+2, rsp_id=0, rsp_data=12, rsp_flags=0000.
REQ-037 req1 SUB (0001) a=3 b=3 -> rsp_id=1, rsp_data=0, rsp_flags=1001 (Z=1, C=1).
REQ-038 Both valid continuously after reset, round-robin build -> grants alternate 0,1,0,1; fixed-priority build -> four grants all to 0.
REQ-039 req0 sel 0010 -> rsp_valid at T+1, rsp_err=1, rsp_data=0; ALU result never captured.
REQ-040 req0 SLT (1101) a=0xFFFFFFFF b=1, rsp_ready low 3 cycles -> rsp_data=1 held stable 3 cycles, req1_valid=1 meanwhile sees req1_ready=0; accepted in first IDLE cycle after handshake.
REQ-041 rst asserted during EXEC -> next cycle IDLE, rsp_valid never rises for aborted op, next tie grants requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: grants one operation at a time, holds it for a
// single execute cycle and presents the captured result. ALU_ARB_FIXED_PRI_EN selects fixed priority.
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_out,
  input  logic         alu_z,
  input  logic         alu_v,
  input  logic         alu_s,
  input  logic         alu_c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_data,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   sel_q, sel_d;
  logic         id_q, id_d;
  logic [N-1:0] data_q, data_d;
  logic [3:0]   flags_q, flags_d;
  logic         err_q, err_d;
`ifndef ALU_ARB_FIXED_PRI_EN
  logic         last_q, last_d;
`endif

  logic         gnt_id_s;
  logic         accept_s;
  logic [N-1:0] sel_a_s;
  logic [N-1:0] sel_b_s;
  logic [3:0]   sel_op_s;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1111: op_supported = 1'b1;
      default:                                      op_supported = 1'b0;
    endcase
  endfunction

  // Arbitration: a tie goes to requester 0 (fixed) or away from the last winner (round-robin).
  always_comb begin
    gnt_id_s = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      gnt_id_s = 1'b0;
`else
      gnt_id_s = ~last_q;
`endif
    end else if (req1_valid) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
  end

  assign accept_s   = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = accept_s && !gnt_id_s;
  assign req1_ready = accept_s && gnt_id_s;
  assign sel_a_s    = gnt_id_s ? req1_a : req0_a;
  assign sel_b_s    = gnt_id_s ? req1_b : req0_b;
  assign sel_op_s   = gnt_id_s ? req1_sel : req0_sel;

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;
  assign rsp_valid  = (state_q == RESP) && !rst;
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

  // Next-state and capture logic; unsupported opcodes skip EXEC and report an error.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    id_d    = id_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;
`ifndef ALU_ARB_FIXED_PRI_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d   = sel_a_s;
          b_d   = sel_b_s;
          sel_d = sel_op_s;
          id_d  = gnt_id_s;
`ifndef ALU_ARB_FIXED_PRI_EN
          last_d = gnt_id_s;
`endif
          if (op_supported(sel_op_s)) begin
            state_d = EXEC;
          end else begin
            state_d = RESP;
            data_d  = '0;
            flags_d = 4'b0000;
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        data_d  = alu_out;
        flags_d = {alu_z, alu_v, alu_s, alu_c};
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 4'b0000;
      id_q    <= 1'b0;
      data_q  <= '0;
      flags_q <= 4'b0000;
      err_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
`ifndef ALU_ARB_FIXED_PRI_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the shared port.
// Expectations for tie vectors follow ALU_ARB_FIXED_PRI_EN.
module tb_alu_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_sel, req1_sel;
  logic [N-1:0] alu_a, alu_b, alu_out;
  logic [3:0]   alu_sel;
  logic         alu_z, alu_v, alu_s, alu_c;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [N-1:0] rsp_data;
  logic [3:0]   rsp_flags;
  logic [N:0]   wide;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_z(alu_z), .alu_v(alu_v), .alu_s(alu_s), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Shared ALU: add/sub/or/slt; other opcodes give a scrambled nonzero value.
  always_comb begin
    wide    = '0;
    alu_out = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (alu_sel)
      4'b0000: begin
        wide    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (alu_a[N-1] == alu_b[N-1]) && (alu_out[N-1] != alu_a[N-1]);
      end
      4'b0001: begin
        wide    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_out = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (alu_a[N-1] != alu_b[N-1]) && (alu_out[N-1] != alu_a[N-1]);
      end
      4'b0100: alu_out = alu_a | alu_b;
      4'b1101: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_out = alu_a ^ alu_b ^ 32'hA5A5_A5A5;
    endcase
    alu_z = (alu_out == 32'd0);
    alu_s = alu_out[N-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_sel = 4'b0000;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_sel = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v0;
    logic [31:0] a0, b0;
    logic [3:0]  s0;
    logic        v1;
    logic [31:0] a1, b1;
    logic [3:0]  s1;
    logic        eid;
    logic [31:0] edata;
    logic [3:0]  eflags;
    logic        eerr;
    int          elat;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic        got, seen, gid;
    int          lat, ng;
    logic [3:0]  grants;
    logic [3:0]  exp_grants;

    vt[0] = '{1'b1, 32'd5, 32'd7, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd12, 4'b0000, 1'b0, 2};
    vt[1] = '{1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'd3, 32'd3, 4'b0001, 1'b1, 32'd0, 4'b1001, 1'b0, 2};
    vt[2] = '{1'b1, 32'd9, 32'd4, 4'b0010, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 4'b0000, 1'b1, 1};
`ifdef ALU_ARB_FIXED_PRI_EN
    vt[3] = '{1'b1, 32'd1, 32'd2, 4'b0000, 1'b1, 32'hF0, 32'h0F, 4'b0100, 1'b0, 32'd3, 4'b0000, 1'b0, 2};
    exp_grants = 4'b0000;
`else
    vt[3] = '{1'b1, 32'd1, 32'd2, 4'b0000, 1'b1, 32'hF0, 32'h0F, 4'b0100, 1'b1, 32'hFF, 4'b0000, 1'b0, 2};
    exp_grants = 4'b1010;
`endif
    vt[4] = '{1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0000, 1'b1, 32'd6, 32'd6, 4'b0001, 1'b0, 32'h8000_0000, 4'b0110, 1'b0, 2};
    vt[5] = '{1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b1, 32'd0, 4'b1001, 1'b0, 2};

    // Reset behaviour: readies held low while rst is high, registers cleared.
    idle_inputs();
    rsp_ready = 1'b0;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    step();

    // Table vectors: accept, latency, captured response, release.
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_valid = vt[i].v0; req0_a = vt[i].a0; req0_b = vt[i].b0; req0_sel = vt[i].s0;
      req1_valid = vt[i].v1; req1_a = vt[i].a1; req1_b = vt[i].b1; req1_sel = vt[i].s1;
      got = 1'b0;
      gid = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          gid = req1_ready;
          chk("single_grant", 32'(req0_ready && req1_ready), 32'd0);
        end else begin
          step();
        end
      end
      chk("accept", 32'(got), 32'd1);
      chk("grant_id", 32'(gid), 32'(vt[i].eid));
      step();
      idle_inputs();
      lat = 1;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge clk);
        if (rsp_valid) begin
          seen = 1'b1;
        end else begin
          lat++;
          step();
        end
      end
      chk("rsp_seen", 32'(seen), 32'd1);
      chk("latency", 32'(lat), 32'(vt[i].elat));
      chk("rsp_id", 32'(rsp_id), 32'(vt[i].eid));
      chk("rsp_data", rsp_data, vt[i].edata);
      chk("rsp_flags", 32'(rsp_flags), 32'(vt[i].eflags));
      chk("rsp_err", 32'(rsp_err), 32'(vt[i].eerr));
      step();
      @(negedge clk);
      chk("rsp_release", 32'(rsp_valid), 32'd0);
      step();
    end

    // Both requesters valid continuously: first four grants.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_sel = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_sel = 4'b0000;
    rsp_ready = 1'b1;
    ng = 0;
    grants = 4'b0000;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        grants[ng] = req1_ready;
        ng++;
      end
      step();
    end
    idle_inputs();
    chk("tie_grant_count", 32'(ng), 32'd4);
    chk("tie_grant_order", 32'(grants), 32'(exp_grants));
    for (int c = 0; c < 4; c++) step();

    // Stalled response: SLT result held, requester 1 kept waiting until after the handshake.
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_sel = 4'b1101;
    @(negedge clk);
    chk("slt_accept", 32'(req0_ready), 32'd1);
    step();
    idle_inputs();
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_sel = 4'b0000;
    @(negedge clk);
    chk("slt_exec_valid", 32'(rsp_valid), 32'd0);
    chk("slt_exec_r1ready", 32'(req1_ready), 32'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("slt_hold_valid", 32'(rsp_valid), 32'd1);
      chk("slt_hold_data", rsp_data, 32'd1);
      chk("slt_hold_r1ready", 32'(req1_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("slt_hs_valid", 32'(rsp_valid), 32'd1);
    chk("slt_hs_r1ready", 32'(req1_ready), 32'd0);
    step();
    @(negedge clk);
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_r1ready", 32'(req1_ready), 32'd1);
    step();
    idle_inputs();
    step();
    @(negedge clk);
    chk("r1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("r1_rsp_id", 32'(rsp_id), 32'd1);
    chk("r1_rsp_data", rsp_data, 32'd4);
    step();
    step();

    // Reset during EXEC aborts the operation and restores the tie-break.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_sel = 4'b0000;
    @(negedge clk);
    chk("abort_accept", 32'(req0_ready), 32'd1);
    step();
    rst = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd8; req1_b = 32'd8; req1_sel = 4'b0000;
    @(negedge clk);
    chk("abort_r0ready", 32'(req0_ready), 32'd0);
    chk("abort_r1ready", 32'(req1_ready), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_valid", 32'(rsp_valid), 32'd0);
    chk("abort_tie_r0", 32'(req0_ready), 32'd1);
    chk("abort_tie_r1", 32'(req1_ready), 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("new_exec_valid", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("new_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("new_rsp_data", rsp_data, 32'd12);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
